// File: rtl/wb_grf.sv
// Writeback stage and 32x32 general register file with write-to-read bypass.
// Optional macro GRF_DISPLAY_EN prints every committed register write (simulation only).
module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_W,
    input  logic [4:0]  RD_W,
    input  logic [31:0] AO_W,
    input  logic [31:0] DR_W,
    input  logic [31:0] PC_W,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WD_W
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] pc_link;
    logic        we;
    logic [31:0] regs [0:31];

    // Only opcode and funct fields steer the writeback mux.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr_W[25:6];

    assign op      = Instr_W[31:26];
    assign funct   = Instr_W[5:0];
    assign pc_link = PC_W + 32'd8;
    assign we      = (RD_W != 5'd0) && !reset;

    always_comb begin
        byte_sel = DR_W[7:0];
        case (AO_W[1:0])
            2'd0: byte_sel = DR_W[7:0];
            2'd1: byte_sel = DR_W[15:8];
            2'd2: byte_sel = DR_W[23:16];
            2'd3: byte_sel = DR_W[31:24];
            default: byte_sel = DR_W[7:0];
        endcase
    end

    // Halfword loads are assumed aligned; AO_W[0] plays no part.
    assign half_sel = AO_W[1] ? DR_W[31:16] : DR_W[15:0];

    always_comb begin
        WD_W = AO_W;
        case (op)
            OP_LW:  WD_W = DR_W;
            OP_LB:  WD_W = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: WD_W = {24'd0, byte_sel};
            OP_LH:  WD_W = {{16{half_sel[15]}}, half_sel};
            OP_LHU: WD_W = {16'd0, half_sel};
            OP_JAL: WD_W = pc_link;
            OP_SPECIAL: begin
                if (funct == FN_JALR) WD_W = pc_link;
            end
            default: WD_W = AO_W;
        endcase
    end

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we) begin
            regs[RD_W] <= WD_W;
        end
    end

    always_comb begin
        if (A1 == 5'd0)
            RD1 = '0;
        else if (A1 == RD_W)
            RD1 = WD_W;
        else
            RD1 = regs[A1];
    end

    always_comb begin
        if (A2 == 5'd0)
            RD2 = '0;
        else if (A2 == RD_W)
            RD2 = WD_W;
        else
            RD2 = regs[A2];
    end

`ifdef GRF_DISPLAY_EN
    always @(posedge clk) begin
        if (we) $display("%d@%h: $%d <= %h", $time, PC_W, RD_W, WD_W);
    end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: reset sequence, directed vector table, reset-discard sequence
// and randomized traffic checked against an array-based register model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_W;
  logic [4:0]  RD_W;
  logic [31:0] AO_W;
  logic [31:0] DR_W;
  logic [31:0] PC_W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;

  wb_grf dut (
    .clk(clk), .reset(reset), .Instr_W(Instr_W), .RD_W(RD_W), .AO_W(AO_W),
    .DR_W(DR_W), .PC_W(PC_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WD_W(WD_W)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ORI  = 32'h3400_0000;
  localparam logic [31:0] I_LB   = 32'h8000_0000;
  localparam logic [31:0] I_LH   = 32'h8400_0000;
  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_LBU  = 32'h9000_0000;
  localparam logic [31:0] I_LHU  = 32'h9400_0000;
  localparam logic [31:0] I_JAL  = 32'h0C00_0000;
  localparam logic [31:0] I_JALR = 32'h03E0_2009;
  localparam logic [31:0] I_ADDU = 32'h0000_0021;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [31:0] pc;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [4:0] rd, input logic [31:0] ao,
                       input logic [31:0] dr, input logic [31:0] pc,
                       input logic [4:0] a1, input logic [4:0] a2);
    Instr_W = instr; RD_W = rd; AO_W = ao; DR_W = dr; PC_W = pc; A1 = a1; A2 = a2;
  endtask

  // Reference writeback value, derived directly from the load/link rules.
  function automatic logic [31:0] ref_wd(input logic [31:0] instr, input logic [31:0] ao,
                                         input logic [31:0] dr, input logic [31:0] pc);
    logic [5:0]         op;
    logic [5:0]         fn;
    logic [31:0]        sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] ext;
    op = instr[31:26];
    fn = instr[5:0];
    if (op == 6'b100000 || op == 6'b100100) begin
      sh = dr >> (8 * ao[1:0]);
      b8 = sh[7:0];
      ext = b8;
      return (op == 6'b100000) ? ext : (sh & 32'hFF);
    end
    if (op == 6'b100001 || op == 6'b100101) begin
      sh = dr >> (16 * ao[1]);
      h16 = sh[15:0];
      ext = h16;
      return (op == 6'b100001) ? ext : (sh & 32'hFFFF);
    end
    if (op == 6'b100011) return dr;
    if (op == 6'b000011 || (op == 6'b000000 && fn == 6'b001001)) return pc + 32'd8;
    return ao;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] a, input logic [4:0] rd,
                                         input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (a == rd) return wd;
    return model[a];
  endfunction

  initial begin
    logic [31:0] instr_pool [9];
    logic [31:0] wd;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  a1;
    logic [4:0]  a2;

    vecs[0]  = '{I_ORI | 32'h1234, 5'd8,  32'h0000_1234, 32'h0, 32'h3000, 5'd8,  5'd0,  32'h0000_1234, 32'h0000_1234, 32'h0};
    vecs[1]  = '{I_LB,   5'd9,  32'h0, 32'h8000_FF7F, 32'h3004, 5'd8,  5'd9,  32'h0000_007F, 32'h0000_1234, 32'h0000_007F};
    vecs[2]  = '{I_LB,   5'd10, 32'h1, 32'h8000_FF7F, 32'h3004, 5'd9,  5'd10, 32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_FFFF};
    vecs[3]  = '{I_LBU,  5'd11, 32'h3, 32'h8000_FF7F, 32'h3004, 5'd10, 5'd11, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_0080};
    vecs[4]  = '{I_LH,   5'd12, 32'h2, 32'h8000_FF7F, 32'h3004, 5'd11, 5'd12, 32'hFFFF_8000, 32'h0000_0080, 32'hFFFF_8000};
    vecs[5]  = '{I_LHU,  5'd13, 32'h1, 32'h8000_FF7F, 32'h3004, 5'd12, 5'd13, 32'h0000_FF7F, 32'hFFFF_8000, 32'h0000_FF7F};
    vecs[6]  = '{I_LW,   5'd14, 32'h0, 32'h8000_FF7F, 32'h3004, 5'd14, 5'd14, 32'h8000_FF7F, 32'h8000_FF7F, 32'h8000_FF7F};
    vecs[7]  = '{I_JAL,  5'd31, 32'h0, 32'h0, 32'h0000_3008, 5'd31, 5'd31, 32'h0000_3010, 32'h0000_3010, 32'h0000_3010};
    vecs[8]  = '{I_JALR, 5'd4,  32'h5555, 32'h0, 32'h0000_3008, 5'd4, 5'd31, 32'h0000_3010, 32'h0000_3010, 32'h0000_3010};
    vecs[9]  = '{I_JAL,  5'd5,  32'h0, 32'h0, 32'hFFFF_FFFC, 5'd5, 5'd4, 32'h0000_0004, 32'h0000_0004, 32'h0000_3010};
    vecs[10] = '{I_ADDU, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'h3010, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    vecs[11] = '{I_ORI | 32'h1, 5'd6, 32'h1, 32'h0, 32'h3014, 5'd13, 5'd14, 32'h1, 32'h0000_FF7F, 32'h8000_FF7F};
    vecs[12] = '{I_LBU,  5'd7,  32'h2, 32'h8000_FF7F, 32'h3018, 5'd7, 5'd6, 32'h0, 32'h0, 32'h1};
    vecs[13] = '{I_LH,   5'd15, 32'h0, 32'h8000_FF7F, 32'h301C, 5'd15, 5'd5, 32'hFFFF_FF7F, 32'hFFFF_FF7F, 32'h0000_0004};

    instr_pool = '{I_ORI, I_LB, I_LH, I_LW, I_LBU, I_LHU, I_JAL, I_JALR, I_ADDU};

    // Clock/reset: two reset edges, then a write attempt on a third reset edge.
    reset = 1'b1;
    drive(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(I_ORI | 32'hAAAA, 5'd5, 32'h0000_AAAA, 32'h0, 32'h3000, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    exp_q.push_back(32'h0);
    check("wd_reset_inputs", WD_W);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      exp_q.push_back(32'h0);
      check("rd1_after_reset", RD1);
      exp_q.push_back(32'h0);
      check("rd2_after_reset", RD2);
    end
    A1 = 5'd5;
    #1;
    exp_q.push_back(32'h0);
    check("reg5_reset_wins", RD1);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Directed vector table; each row commits on the following edge.
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive(vecs[v].instr, vecs[v].rd, vecs[v].ao, vecs[v].dr, vecs[v].pc, vecs[v].a1, vecs[v].a2);
      #1;
      exp_q.push_back(vecs[v].exp_wd);
      check($sformatf("vec%0d_wd", v), WD_W);
      exp_q.push_back(vecs[v].exp_rd1);
      check($sformatf("vec%0d_rd1", v), RD1);
      exp_q.push_back(vecs[v].exp_rd2);
      check($sformatf("vec%0d_rd2", v), RD2);
      if (vecs[v].rd != 0) model[vecs[v].rd] = vecs[v].exp_wd;
    end

    // Stored $8 after the bypass case, and nothing landed from the RD_W=0 row.
    @(negedge clk);
    drive(I_ADDU, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
    #1;
    exp_q.push_back(32'h0000_1234);
    check("reg8_stored", RD1);
    exp_q.push_back(32'h0000_0004);
    A2 = 5'd5;
    #1;
    check("reg5_wrapped", RD2);

    // Reset mid-stream discards the write presented on the reset edge.
    @(negedge clk);
    drive(I_ORI, 5'd20, 32'h0000_1111, 32'h0, 32'h3020, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(I_ORI, 5'd21, 32'h0000_2222, 32'h0, 32'h3024, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd20, 5'd21);
    #1;
    exp_q.push_back(32'h0);
    check("reg20_cleared", RD1);
    exp_q.push_back(32'h0);
    check("reg21_discarded", RD2);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Randomized traffic against the register model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        instr = $urandom();
      else
        instr = instr_pool[$urandom_range(0, 8)] | ($urandom() & 32'h03FF_FFC0);
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(instr, rd, $urandom(), $urandom(), $urandom(), a1, a2);
      #1;
      wd = ref_wd(Instr_W, AO_W, DR_W, PC_W);
      exp_q.push_back(wd);
      check("rand_wd", WD_W);
      exp_q.push_back(ref_rd(a1, rd, wd));
      check("rand_rd1", RD1);
      exp_q.push_back(ref_rd(a2, rd, wd));
      check("rand_rd2", RD2);
      if (rd != 0) model[rd] = wd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
